conv_window_addr_gen: RTL

Consumes the signed (height, width) anchor stream produced by `ConvAnchorGen_2D` and expands each anchor into the K_H×K_W feature-map read addresses of its convolution window.
- Flags out-of-bounds (padding) taps so the MAC stage substitutes zero.
- Sits between the anchor generator and the feature-map buffer read port.
- Throttles the anchor generator through its `pause` input while a window is being walked.

---
 rtl/conv_pkg.sv | 27 ++
 rtl/window_tap_counter.sv | 95 +++++++++
 rtl/conv_window_addr_gen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution anchor generator and window address generator.
package conv_pkg;

    // Window walker state.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } conv_state_t;

    // Signed feature-map coordinate; anchors may sit above/left of the map.
    typedef logic signed [31:0] coord_t;

    // Default map and kernel geometry, shared with ConvAnchorGen_2D.
    localparam int DEF_IN_H   = 28;
    localparam int DEF_IN_W   = 28;
    localparam int DEF_K_H    = 3;
    localparam int DEF_K_W    = 3;
    localparam int DEF_ADDR_W = 16;

    // True when (row, col) lies outside an in_h x in_w map.
    function automatic logic tap_is_pad(input coord_t row, input coord_t col,
                                        input int in_h, input int in_w);
        return (row < 0) || (row >= coord_t'(in_h)) ||
               (col < 0) || (col >= coord_t'(in_w));
    endfunction

endpackage

// File: rtl/window_tap_counter.sv
// Kernel tap walker: kr/kc counters, running row base and last-tap detect.
// The nxt_* outputs describe the tap that the next load or advance will present.
module window_tap_counter
    import conv_pkg::*;
#(
    parameter int IN_W = DEF_IN_W,
    parameter int K_H  = DEF_K_H,
    parameter int K_W  = DEF_K_W
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clear,
    input  logic   load,
    input  logic   advance,
    input  coord_t anchor_height,
    input  coord_t anchor_width,
    output coord_t nxt_row,
    output coord_t nxt_col,
    output coord_t nxt_row_base,
    output logic   nxt_last
);

    localparam int KR_W = (K_H > 1) ? $clog2(K_H) : 1;
    localparam int KC_W = (K_W > 1) ? $clog2(K_W) : 1;
    localparam logic [KR_W-1:0] KR_MAX = KR_W'(K_H - 1);
    localparam logic [KC_W-1:0] KC_MAX = KC_W'(K_W - 1);

    logic [KR_W-1:0] kr_q, kr_d;
    logic [KC_W-1:0] kc_q, kc_d;
    coord_t          row_q, row_d;
    coord_t          col_q, col_d;
    coord_t          row_base_q, row_base_d;
    coord_t          anchor_w_q;

    // Next tap: first tap of a fresh anchor on load, otherwise step kc then kr.
    always_comb begin
        kr_d       = kr_q;
        kc_d       = kc_q;
        row_d      = row_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        if (load) begin
            kr_d       = '0;
            kc_d       = '0;
            row_d      = anchor_height;
            col_d      = anchor_width;
            // Constant-coefficient product, only once per window; later rows
            // are reached by the running +IN_W accumulator below.
            row_base_d = anchor_height * coord_t'(IN_W);
        end else if (kc_q == KC_MAX) begin
            kr_d       = kr_q + KR_W'(1);
            kc_d       = '0;
            row_d      = row_q + coord_t'(1);
            col_d      = anchor_w_q;
            row_base_d = row_base_q + coord_t'(IN_W);
        end else begin
            kc_d       = kc_q + KC_W'(1);
            col_d      = col_q + coord_t'(1);
        end
    end

    assign nxt_row      = row_d;
    assign nxt_col      = col_d;
    assign nxt_row_base = row_base_d;
    assign nxt_last     = (kr_d == KR_MAX) && (kc_d == KC_MAX);

    // Counter registers; clear wins so an abandoned window leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kr_q       <= '0;
            kc_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            anchor_w_q <= '0;
        end else if (clear) begin
            kr_q       <= '0;
            kc_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            anchor_w_q <= '0;
        end else if (load || advance) begin
            kr_q       <= kr_d;
            kc_q       <= kc_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            if (load) begin
                anchor_w_q <= anchor_width;
            end
        end
    end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Expands each signed conv anchor into K_H x K_W feature-map read taps,
// flagging padding taps, and holds the anchor generator while walking.
//
// state | meaning
// IDLE  | no window; anchor_pause low, waiting for enable && anchor_valid
// BUSY  | walking a captured window; anchor_pause high, one tap presented
module conv_window_addr_gen
    import conv_pkg::*;
#(
    parameter int IN_H      = DEF_IN_H,
    parameter int IN_W      = DEF_IN_W,
    parameter int K_H       = DEF_K_H,
    parameter int K_W       = DEF_K_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              anchor_valid,
    input  logic [31:0]       anchor_height,
    input  logic [31:0]       anchor_width,
    output logic              anchor_pause,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_pad,
    output logic              pix_last
);

    conv_state_t state_q, state_d;
    logic        load;
    logic        advance;
    logic        clear;
    logic        finish;

    coord_t      nxt_row;
    coord_t      nxt_col;
    coord_t      nxt_row_base;
    logic        nxt_last;
    logic        nxt_pad;
    logic [ADDR_W-1:0] nxt_addr;

    window_tap_counter #(
        .IN_W (IN_W),
        .K_H  (K_H),
        .K_W  (K_W)
    ) u_tap_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear || finish),
        .load          (load),
        .advance       (advance),
        .anchor_height (coord_t'(anchor_height)),
        .anchor_width  (coord_t'(anchor_width)),
        .nxt_row       (nxt_row),
        .nxt_col       (nxt_col),
        .nxt_row_base  (nxt_row_base),
        .nxt_last      (nxt_last)
    );

    // Bounds check and address of the upcoming tap; padded taps carry address 0.
    always_comb begin
        nxt_pad  = tap_is_pad(nxt_row, nxt_col, IN_H, IN_W);
        nxt_addr = '0;
        if (!nxt_pad) begin
            nxt_addr = ADDR_W'(coord_t'(BASE_ADDR) + nxt_row_base + nxt_col);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and tap-control decode; enable low overrides everything.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        clear   = 1'b0;
        finish  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            clear   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (anchor_valid) begin
                        state_d = BUSY;
                        load    = 1'b1;
                    end
                end
                BUSY: begin
                    if (pix_valid && pix_ready) begin
                        if (pix_last) begin
                            state_d = IDLE;
                            finish  = 1'b1;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end
            endcase
        end
    end

    // Pause is a pure decode of the state flop, so pix_ready never reaches it.
    assign anchor_pause = (state_q == BUSY);

    // Output tap register: loads on capture or handshake, holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_addr  <= '0;
            pix_pad   <= 1'b0;
            pix_last  <= 1'b0;
        end else if (clear || finish) begin
            pix_valid <= 1'b0;
            pix_addr  <= '0;
            pix_pad   <= 1'b0;
            pix_last  <= 1'b0;
        end else if (load || advance) begin
            pix_valid <= 1'b1;
            pix_addr  <= nxt_addr;
            pix_pad   <= nxt_pad;
            pix_last  <= nxt_last;
        end
    end

endmodule
